// File: rtl/fifo_tx_frame_reader.sv
// Transmit-side reader of the synchronous frame FIFO, clocked on the FIFO read clock.
// Pops {eof, byte} words (1-cycle read latency) into a 2-entry skid buffer and presents
// them to the MAC as a valid/ready byte stream. Frames start on a fill threshold or
// after a timeout. Runs that go dry mid-frame are flagged and drained. Frames longer
// than c_MAX_FRAME are truncated and drained. An inter-frame gap follows every frame.
//
// Ports:
//   rd_clk, rd_rst_n      clock, asynchronous active-low reset
//   fifo_rd_data          {eof, byte}, valid the cycle after an accepted fifo_rd_en
//   fifo_rd_empty         FIFO empty flag
//   fifo_rd_water_level   FIFO read-side fill level
//   fifo_rd_en            FIFO pop request
//   tx_data/valid/last    byte stream to the MAC, tx_ready accepts
//   underrun_err          1-cycle pulse when the FIFO runs dry mid-frame
//   oversize_err          1-cycle pulse on the truncating byte of an oversize frame
//   frame_cnt             frames sent with a good tail (wraps)
module fifo_tx_frame_reader #(
   parameter int unsigned c_DATA_WIDTH     = 8,
   parameter int unsigned c_RD_DEPTH_WIDTH = 10,
   parameter int unsigned c_START_LEVEL    = 64,
   parameter int unsigned c_START_TIMEOUT  = 255,
   parameter int unsigned c_IFG_CYCLES     = 12,
   parameter int unsigned c_MAX_FRAME      = 1518
) (
   input  logic                      rd_clk,
   input  logic                      rd_rst_n,
   input  logic [c_DATA_WIDTH:0]     fifo_rd_data,
   input  logic                      fifo_rd_empty,
   input  logic [c_RD_DEPTH_WIDTH:0] fifo_rd_water_level,
   output logic                      fifo_rd_en,
   output logic [c_DATA_WIDTH-1:0]   tx_data,
   output logic                      tx_valid,
   output logic                      tx_last,
   input  logic                      tx_ready,
   output logic                      underrun_err,
   output logic                      oversize_err,
   output logic [15:0]               frame_cnt
);

   typedef enum logic [1:0] {StIdle, StSend, StDrain, StGap} state_e;

   localparam logic [15:0] LastIdx = 16'(c_MAX_FRAME - 1);

   state_e                state_q;
   logic [c_DATA_WIDTH:0] skid_q [2];
   logic [c_DATA_WIDTH:0] skid_d [2];
   logic [1:0]            cnt_q, cnt_d, cnt_after;
   logic                  inflight_q;
   logic                  eof_fetched_q;
   logic [15:0]           byte_cnt_q, wait_cnt_q, gap_cnt_q, frame_cnt_q;

   logic       head_eof, at_limit, xfer, discard, pop, underrun;
   logic       eof_seen, rd_allowed, level_zero, start_now;
   logic [1:0] occ;

   always_comb begin
      head_eof   = skid_q[0][c_DATA_WIDTH];
      at_limit   = (byte_cnt_q == LastIdx);
      tx_valid   = (state_q == StSend) && (cnt_q != 2'd0);
      tx_data    = tx_valid ? skid_q[0][c_DATA_WIDTH-1:0] : '0;
      tx_last    = tx_valid && (head_eof || at_limit);
      xfer       = tx_valid && tx_ready;
      discard    = (state_q == StDrain) && (cnt_q != 2'd0);
      pop        = xfer || discard;
      // Dry only counts once the frame has started; before the first byte SEND just waits.
      underrun   = (state_q == StSend) && (byte_cnt_q != 16'd0) && tx_ready &&
                   (cnt_q == 2'd0) && !inflight_q;
      // An eof word landing this cycle must already block the next read, otherwise the
      // following frame's first word would be pre-loaded.
      eof_seen   = eof_fetched_q || (inflight_q && fifo_rd_data[c_DATA_WIDTH]);
      rd_allowed = ((state_q == StSend) || (state_q == StDrain)) && !eof_seen;
      occ        = cnt_q + {1'b0, inflight_q};
      fifo_rd_en = rd_allowed && !fifo_rd_empty && ((occ - {1'b0, xfer}) < 2'd2);
      underrun_err = underrun;
      oversize_err = xfer && at_limit && !head_eof;
      frame_cnt    = frame_cnt_q;
      level_zero   = (fifo_rd_water_level == '0);
      start_now    = !level_zero &&
                     ((32'(fifo_rd_water_level) >= c_START_LEVEL) ||
                      ((32'(wait_cnt_q) + 32'd1) >= c_START_TIMEOUT));
   end

   // Skid buffer: entry 0 is the head; returning read data lands behind what remains.
   always_comb begin
      skid_d    = skid_q;
      cnt_after = cnt_q - {1'b0, pop};
      if (pop) begin
         skid_d[0] = skid_q[1];
      end
      cnt_d = cnt_after;
      if (inflight_q) begin
         if (cnt_after == 2'd0) begin
            skid_d[0] = fifo_rd_data;
         end else begin
            skid_d[1] = fifo_rd_data;
         end
         cnt_d = cnt_after + 2'd1;
      end
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state_q       <= StIdle;
         skid_q[0]     <= '0;
         skid_q[1]     <= '0;
         cnt_q         <= 2'd0;
         inflight_q    <= 1'b0;
         eof_fetched_q <= 1'b0;
         byte_cnt_q    <= 16'd0;
         wait_cnt_q    <= 16'd0;
         gap_cnt_q     <= 16'd0;
         frame_cnt_q   <= 16'd0;
      end else begin
         skid_q     <= skid_d;
         cnt_q      <= cnt_d;
         inflight_q <= fifo_rd_en;
         if (inflight_q && fifo_rd_data[c_DATA_WIDTH]) begin
            eof_fetched_q <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (level_zero) begin
                  wait_cnt_q <= 16'd0;
               end else if (start_now) begin
                  wait_cnt_q <= 16'd0;
                  state_q    <= StSend;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 16'd1;
               end
            end
            StSend: begin
               if (xfer) begin
                  if (head_eof) begin
                     // A good eof wins even on the c_MAX_FRAME-th byte.
                     frame_cnt_q <= frame_cnt_q + 16'd1;
                     byte_cnt_q  <= 16'd0;
                     state_q     <= StGap;
                  end else if (at_limit) begin
                     byte_cnt_q <= 16'd0;
                     state_q    <= StDrain;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 16'd1;
                  end
               end else if (underrun) begin
                  byte_cnt_q <= 16'd0;
                  state_q    <= StDrain;
               end
            end
            StDrain: begin
               if (discard && head_eof) begin
                  state_q <= StGap;
               end
            end
            StGap: begin
               if ((32'(gap_cnt_q) + 32'd1) >= c_IFG_CYCLES) begin
                  gap_cnt_q     <= 16'd0;
                  eof_fetched_q <= 1'b0;
                  state_q       <= StIdle;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 16'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_tx_frame_reader.sv
// Bench for fifo_tx_frame_reader: a queue-based FIFO feeds the DUT, and a frame-level
// model lists the bytes the MAC must see, with tx_last / oversize / good-tail marks.
module tb_fifo_tx_frame_reader;

   localparam int DW    = 8;
   localparam int MAXF  = 1518;
   localparam int IFG   = 12;
   localparam int START = 64;
   localparam int TMO   = 255;

   logic          rd_clk   = 1'b0;
   logic          rd_rst_n = 1'b1;
   logic [DW:0]   fifo_rd_data = '0;
   logic          fifo_rd_empty = 1'b1;
   logic [10:0]   fifo_rd_water_level = '0;
   logic          fifo_rd_en;
   logic [DW-1:0] tx_data;
   logic          tx_valid, tx_last;
   logic          tx_ready = 1'b0;
   logic          underrun_err, oversize_err;
   logic [15:0]   frame_cnt;

   fifo_tx_frame_reader dut (
      .rd_clk              (rd_clk),
      .rd_rst_n            (rd_rst_n),
      .fifo_rd_data        (fifo_rd_data),
      .fifo_rd_empty       (fifo_rd_empty),
      .fifo_rd_water_level (fifo_rd_water_level),
      .fifo_rd_en          (fifo_rd_en),
      .tx_data             (tx_data),
      .tx_valid            (tx_valid),
      .tx_last             (tx_last),
      .tx_ready            (tx_ready),
      .underrun_err        (underrun_err),
      .oversize_err        (oversize_err),
      .frame_cnt           (frame_cnt)
   );

   always #5 rd_clk = ~rd_clk;

   typedef struct {
      logic [7:0] d;
      bit         last;
      bit         ovs;
      bit         good;
      bit         arm;   // last byte present before an expected underrun
   } exp_t;

   exp_t        exp_q[$];
   logic [DW:0] fq[$];       // FIFO contents
   logic [DW:0] rest_q[$];   // withheld tail of an underrun frame
   logic [DW:0] pend_word;
   bit          pend_vld;

   int n_checks = 0, n_errs = 0, cyc = 0;
   int exp_frames = 0, und_armed = 0, und_seen = 0, und_expected = 0;
   int ready_mode = 0;
   bit prev_stall = 0;
   logic [7:0] prev_data;
   logic prev_last;
   int last_end_cyc = -1000;
   int nz_cyc, hi_cyc, rd_cyc, first_x, last_x, nxfer;

   task automatic chk(input bit ok, input string name, input longint act, input longint req);
      n_checks++;
      if (!ok) begin
         n_errs++;
         $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
      end
   endtask

   task automatic probe_reset();
      nz_cyc = -1; hi_cyc = -1; rd_cyc = -1; first_x = -1; last_x = -1; nxfer = 0;
   endtask

   // Frame of len bytes; only the first 'present' words go into the FIFO now.
   task automatic add_frame(input int len, input int present);
      int n;
      logic [7:0] b;
      logic [DW:0] w;
      exp_t e;
      n = (len > MAXF) ? MAXF : len;
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom);
         w = {(i == len - 1), b};
         if (i < present) fq.push_back(w);
         else rest_q.push_back(w);
         e.d = b; e.last = 0; e.ovs = 0; e.good = 0; e.arm = 0;
         if (present < len) begin
            if (i < present) begin
               e.arm = (i == present - 1);
               exp_q.push_back(e);
            end
         end else if (i < n) begin
            e.last = (i == n - 1);
            e.ovs  = (len > MAXF) && (i == n - 1);
            e.good = (len <= MAXF) && (i == len - 1);
            exp_q.push_back(e);
         end
      end
      if (present < len) und_expected++;
   endtask

   task automatic step();
      exp_t e;
      bit   xfer;
      @(negedge rd_clk);
      cyc++;
      fifo_rd_data = pend_vld ? pend_word : 9'($urandom);
      pend_vld = 1'b0;
      fifo_rd_empty = (fq.size() == 0);
      fifo_rd_water_level = 11'(fq.size());
      case (ready_mode)
         0: tx_ready = 1'b1;
         1: tx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (nz_cyc < 0 && fifo_rd_water_level != 0) nz_cyc = cyc;
      if (hi_cyc < 0 && fifo_rd_water_level >= START) hi_cyc = cyc;
      if (rd_cyc < 0 && fifo_rd_en) rd_cyc = cyc;
      if (fifo_rd_en) chk(!fifo_rd_empty, "rd_en_while_empty", fifo_rd_empty, 0);
      chk(frame_cnt == 16'(exp_frames), "frame_cnt", frame_cnt, exp_frames);
      if (prev_stall)
         chk(tx_valid && tx_data == prev_data && tx_last == prev_last, "stall_hold",
             {tx_valid, tx_data, tx_last}, {1'b1, prev_data, prev_last});
      if (cyc - last_end_cyc >= 1 && cyc - last_end_cyc <= IFG)
         chk(!tx_valid, "ifg_valid", tx_valid, 0);
      xfer = tx_valid && tx_ready;
      if (xfer) begin
         chk(exp_q.size() != 0, "unexpected_xfer", tx_data, -1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(tx_data == e.d, "tx_data", tx_data, e.d);
            chk(tx_last == e.last, "tx_last", tx_last, e.last);
            chk(oversize_err == e.ovs, "oversize_err", oversize_err, e.ovs);
            if (e.good) exp_frames++;
            if (e.arm) und_armed = 1;
            if (e.last) last_end_cyc = cyc;
         end
         if (first_x < 0) first_x = cyc;
         last_x = cyc;
         nxfer++;
      end else begin
         chk(!oversize_err, "oversize_idle", oversize_err, 0);
      end
      if (underrun_err) begin
         chk(und_armed == 1 && !tx_valid, "underrun_err", und_armed, 1);
         und_armed = 0;
         und_seen++;
         last_end_cyc = cyc;
      end
      if (fifo_rd_en && fq.size() != 0) begin
         pend_word = fq.pop_front();
         pend_vld  = 1'b1;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      while ((exp_q.size() != 0 || fq.size() != 0 || und_armed != 0 || pend_vld) && k < budget) begin
         step();
         k++;
      end
      chk(k < budget, name, k, budget);
      repeat (IFG + 8) step();
   endtask

   initial begin
      int k, u0;
      #2 rd_rst_n = 1'b0;
      #1;
      chk({tx_valid, tx_last, fifo_rd_en, underrun_err, oversize_err} == 5'b0, "reset_ctl",
          {tx_valid, tx_last, fifo_rd_en, underrun_err, oversize_err}, 0);
      chk(frame_cnt == 16'd0, "reset_frame_cnt", frame_cnt, 0);
      repeat (3) step();
      rd_rst_n = 1'b1;
      repeat (4) step();

      // Good frame, threshold start, full throughput.
      probe_reset();
      add_frame(100, 100);
      wait_idle(2000, "good_timeout");
      chk(rd_cyc - hi_cyc == 1, "start_latency", rd_cyc - hi_cyc, 1);
      chk(last_x - first_x == 99, "throughput", last_x - first_x, 99);
      chk(nxfer == 100, "good_count", nxfer, 100);
      chk(frame_cnt == 16'd1, "good_frame_cnt", frame_cnt, 1);

      // Backpressure 1,0,0,1.
      ready_mode = 1;
      probe_reset();
      add_frame(100, 100);
      wait_idle(3000, "bp_timeout");
      chk(nxfer == 100, "bp_count", nxfer, 100);
      chk(frame_cnt == 16'd2, "bp_frame_cnt", frame_cnt, 2);

      // Short frame, timeout start.
      ready_mode = 0;
      probe_reset();
      add_frame(10, 10);
      wait_idle(2000, "short_timeout");
      chk(rd_cyc - nz_cyc == TMO, "timeout_start", rd_cyc - nz_cyc, TMO);
      chk(nxfer == 10, "short_count", nxfer, 10);

      // Underrun after byte 70; tail arrives 50 cycles later and is drained.
      probe_reset();
      u0 = und_seen;
      add_frame(100, 70);
      k = 0;
      while (und_seen == u0 && k < 1000) begin step(); k++; end
      chk(und_seen == u0 + 1, "underrun_seen", und_seen - u0, 1);
      repeat (50) step();
      while (rest_q.size() != 0) fq.push_back(rest_q.pop_front());
      wait_idle(2000, "underrun_drain");
      chk(nxfer == 70, "underrun_count", nxfer, 70);
      chk(frame_cnt == 16'd3, "underrun_frame_cnt", frame_cnt, 3);

      // Oversize frame followed directly by a clean frame.
      probe_reset();
      add_frame(1600, 1600);
      add_frame(20, 20);
      wait_idle(6000, "oversize_timeout");
      chk(nxfer == MAXF + 20, "oversize_count", nxfer, MAXF + 20);
      chk(frame_cnt == 16'd4, "oversize_frame_cnt", frame_cnt, 4);

      // eof exactly on the c_MAX_FRAME-th byte is a good frame.
      probe_reset();
      add_frame(MAXF, MAXF);
      wait_idle(4000, "maxf_timeout");
      chk(frame_cnt == 16'd5, "maxf_frame_cnt", frame_cnt, 5);

      // Random lengths and random backpressure.
      ready_mode = 2;
      for (int b = 0; b < 4; b++) begin
         for (int f = 0; f < 3; f++) add_frame($urandom_range(1, 150), 0 + 1000);
         wait_idle(8000, "random_timeout");
      end

      // Asynchronous reset at byte 40.
      ready_mode = 0;
      probe_reset();
      add_frame(100, 100);
      k = 0;
      while (nxfer < 40 && k < 1000) begin step(); k++; end
      chk(nxfer == 40, "pre_reset_bytes", nxfer, 40);
      #1 rd_rst_n = 1'b0;
      #1;
      chk({tx_valid, tx_last, fifo_rd_en, underrun_err, oversize_err} == 5'b0, "async_reset_ctl",
          {tx_valid, tx_last, fifo_rd_en, underrun_err, oversize_err}, 0);
      chk(tx_data == 8'd0, "async_reset_data", tx_data, 0);
      chk(frame_cnt == 16'd0, "async_reset_frame_cnt", frame_cnt, 0);
      fq.delete(); exp_q.delete(); rest_q.delete();
      pend_vld = 0; exp_frames = 0; und_armed = 0; prev_stall = 0; last_end_cyc = -1000;
      repeat (3) step();
      rd_rst_n = 1'b1;
      repeat (4) step();
      probe_reset();
      add_frame(80, 80);
      wait_idle(2000, "post_reset_timeout");
      chk(rd_cyc - hi_cyc == 1, "post_reset_start", rd_cyc - hi_cyc, 1);
      chk(frame_cnt == 16'd1, "post_reset_frame_cnt", frame_cnt, 1);

      chk(und_seen == und_expected, "underrun_total", und_seen, und_expected);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_tx_frame_reader.md
Name: fifo_tx_frame_reader

Overview:
- Downstream consumer of the synchronous frame FIFO on the MAC transmit path, clocked on the FIFO read clock.
- Pops {eof, byte} words from the FIFO, which has 1-cycle read latency with no output register.
- Presents the words as a valid/ready byte stream to the MAC transmit client.
- Adds a start threshold with timeout, underrun detection, oversize truncation, tail draining and inter-frame gap insertion.

Parameters:
- c_DATA_WIDTH, 8: payload bits per FIFO word. The FIFO word width is c_DATA_WIDTH+1, and the MSB is the eof flag.
- c_RD_DEPTH_WIDTH, 10: FIFO read depth width. It sets the width of the water level input.
- c_START_LEVEL, 64: the water level at or above which a frame starts immediately.
- c_START_TIMEOUT, 255: number of IDLE cycles with a non-zero level after which a frame starts regardless of level. Legal range is 1 to 65535.
- c_IFG_CYCLES, 12: idle cycles inserted after each frame.
- c_MAX_FRAME, 1518: maximum number of bytes per frame before truncation.

Ports:
- rd_clk, input, 1: the single clock.
- rd_rst_n, input, 1: asynchronous reset, active-low.
- fifo_rd_data, input, c_DATA_WIDTH+1: FIFO read data, valid 1 cycle after an accepted fifo_rd_en.
- fifo_rd_empty, input, 1: FIFO empty flag.
- fifo_rd_water_level, input, c_RD_DEPTH_WIDTH+1: FIFO read-side fill level.
- fifo_rd_en, output, 1: FIFO pop request.
- tx_data, output, c_DATA_WIDTH: stream byte.
- tx_valid, output, 1: stream valid.
- tx_last, output, 1: last byte of the frame.
- tx_ready, input, 1: MAC accepts the byte.
- underrun_err, output, 1: 1-cycle pulse when the FIFO runs dry mid-frame.
- oversize_err, output, 1: 1-cycle pulse when a frame is truncated at c_MAX_FRAME.
- frame_cnt, output, 16: count of frames sent with a good tail. Wraps.

Behaviour:
- Reset (rd_rst_n=0, asynchronous): every output is 0, state is IDLE, skid buffer is empty, all counters are 0.
  - A FIFO read in flight at reset is lost. The FIFO must be reset in the same domain.
- Transfer rule: a transfer occurs when tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_last are held stable.
  - tx_valid never drops without a transfer, except through the underrun rule.
- Skid buffer: 2 entries. Let occ = buffer entries + in-flight reads.
  - fifo_rd_en = rd_allowed & !fifo_rd_empty & ((occ - transfer_this_cycle) < 2).
  - fifo_rd_en is never asserted while fifo_rd_empty=1.
  - A read issued in cycle N writes the buffer in cycle N+1.
  - With tx_ready held at 1, sustained throughput is 1 byte per cycle.
- State machine: IDLE, SEND, DRAIN, GAP.
- IDLE: no reads, tx_valid=0.
  - The wait counter increments while the level is non-zero, and clears when the level is 0.
  - Go to SEND when level >= c_START_LEVEL, or when level != 0 and the wait counter reaches c_START_TIMEOUT.
- SEND: reads are allowed. The byte counter increments on each transfer.
  - tx_last = eof bit of the head entry, or byte counter == c_MAX_FRAME-1.
  - Transfer with eof=1: frame_cnt increments, byte counter clears, go to GAP.
  - Transfer at the c_MAX_FRAME-th byte with eof=0: tx_last=1 on that byte, oversize_err pulses in the same cycle, go to DRAIN.
  - Underrun: after the first transfer of a frame, tx_ready=1 while the buffer is empty and nothing is in flight.
    - underrun_err pulses in that cycle and the state goes to DRAIN.
    - tx_last is not issued. The MAC aborts on the valid gap.
    - An underrun before the first byte does not fire; SEND simply waits.
- DRAIN: reads are allowed and buffer entries are discarded at 1 per cycle; tx_valid=0.
  - Exit to GAP once the eof word is discarded. frame_cnt is not incremented.
  - If the FIFO is empty, DRAIN waits indefinitely.
- GAP: no reads, tx_valid=0. Counts c_IFG_CYCLES cycles, then goes to IDLE.
  - Skid entries fetched ahead of time belong only to the current frame. Reads stop once an eof word has been fetched, so a new frame never pre-loads.
- Simultaneous events:
  - If the eof byte is also the c_MAX_FRAME-th byte, it is treated as a good eof: no oversize_err, go to GAP.
  - A level that drops to 0 in IDLE clears the wait counter.
- Widths: the byte counter is 16 bits. The GAP and wait counters are 16 bits.

Test Plan:
- Good frame: load a 100-byte frame (eof on byte 100) into the FIFO, level 100, tx_ready=1.
  - SEND is entered 1 cycle after the level reaches 64.
  - 100 consecutive transfers, tx_last only on byte 100, frame_cnt=1.
  - tx_valid stays 0 for 12 cycles afterwards.
- Backpressure: same frame with tx_ready toggling 1,0,0,1 repeatedly.
  - tx_data is stable while stalled, 100 bytes in order, no underrun_err.
  - fifo_rd_en is never asserted while empty.
- Short frame timeout: a 10-byte frame, level 10.
  - Start occurs exactly 255 IDLE cycles after the level becomes non-zero, then 10 bytes are sent.
- Underrun: a 100-byte frame where only 70 bytes are present at start, and the remaining 30 bytes are written 50 cycles later.
  - underrun_err pulses once after byte 70, with no tx_last.
  - The remaining 30 bytes are drained silently, frame_cnt unchanged, then IFG.
- Oversize: a 1600-byte frame with c_MAX_FRAME=1518.
  - tx_last and oversize_err occur on byte 1518.
  - 82 bytes are drained, and the next frame starts cleanly with frame_cnt unchanged.
- Reset mid-frame: assert rd_rst_n=0 at byte 40.
  - All outputs go to 0 asynchronously, and the state is IDLE after release.
